// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR plus pass-through.
// One registered stage per shift-amount bit, valid/ready at both ends.
//
// Parameters:
//   WIDTH    data width, power of two, >= 4
//   SHAMT_W  derived shift-amount width and pipeline depth
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = pipeline may advance)
//   in_data/in_shamt    operand and shift amount
//   in_op               000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR,
//                       others pass-through
//   out_valid/out_ready output handshake
//   out_data/out_zero   result and registered all-zero flag
module pipelined_barrel_shifter #(
    parameter  int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef struct packed {
        logic               valid;
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        logic [2:0]         op;
        logic               msb;
    } stage_t;

    // Shift by the constant s when en is set. The SRA fill uses the
    // operand's original MSB carried down the pipe.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             msb,
        input logic             en,
        input int               s
    );
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] r;
        fill = msb ? ~({WIDTH{1'b1}} >> s) : '0;
        r    = d;
        if (en) begin
            unique case (op)
                OP_SLL:  r = d << s;
                OP_SRL:  r = d >> s;
                OP_SRA:  r = (d >> s) | fill;
                OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
                OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
                default: r = d;
            endcase
        end
        return r;
    endfunction

    logic   adv;
    stage_t in_stage;

    // Whole-pipe stall: nothing moves while the output is blocked.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        in_stage       = '0;
        in_stage.valid = in_valid;
        in_stage.data  = in_data;
        in_stage.shamt = in_shamt;
        in_stage.op    = in_op;
        in_stage.msb   = in_data[WIDTH-1];
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        stage_t src;
        stage_t stage_d;
        stage_t stage_q;

        if (k == 0) begin : g_first
            assign src = in_stage;
        end else begin : g_next
            assign src = g_stage[k-1].stage_q;
        end

        // Bubbles flow like real beats; only the valid bit marks them.
        always_comb begin
            stage_d      = src;
            stage_d.data = shift_stage(src.data, src.op, src.msb,
                                       src.shamt[k], 1 << k);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stage_q <= '0;
            end else if (adv) begin
                stage_q <= stage_d;
            end
        end
    end

    logic zero_d;
    logic zero_q;

    // Zero flag computed from the last stage's next data so it lands
    // in a register together with out_data.
    assign zero_d = ~|g_stage[SHAMT_W-1].stage_d.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (adv) begin
            zero_q <= zero_d;
        end
    end

    assign out_valid = g_stage[SHAMT_W-1].stage_q.valid;
    assign out_data  = g_stage[SHAMT_W-1].stage_q.data;
    assign out_zero  = zero_q;

    logic unused_tail;
    assign unused_tail = ^{g_stage[SHAMT_W-1].stage_q.shamt,
                           g_stage[SHAMT_W-1].stage_q.op,
                           g_stage[SHAMT_W-1].stage_q.msb};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8).
// Directed cases plus randomized beats against a queue-based model.
module tb_pipelined_barrel_shifter;

    localparam int W = 8;
    localparam int L = 3;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_shamt;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_zero;

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int stalls = 0;
    bit rand_rdy = 0;
    bit head_seen = 0;

    typedef struct {
        int res;
        int acc;
        int snap;
    } exp_t;
    exp_t q[$];

    function automatic int ref_shift(int d, int s, int op);
        int sd;
        case (op)
            0: return (d << s) & 255;
            1: return d >> s;
            2: begin
                sd = (d >= 128) ? d - 256 : d;
                return (sd >>> s) & 255;
            end
            3: return ((d << s) | (d >> (8 - s))) & 255;
            4: return ((d >> s) | (d << (8 - s))) & 255;
            default: return d;
        endcase
    endfunction

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Compare process: every cycle with out_valid is checked against
    // the head of the model queue, which also enforces output hold.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            head_seen = 0;
        end else begin
            chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("out_data", int'(out_data), q[0].res);
                    chk("out_zero", int'(out_zero), int'(q[0].res == 0));
                    if (!head_seen)
                        chk("latency", cyc - q[0].acc,
                            L + (stalls - q[0].snap));
                    head_seen = 1;
                    if (out_ready) begin
                        void'(q.pop_front());
                        head_seen = 0;
                    end
                end
            end
            if (!(!out_valid || out_ready)) stalls++;
            if (in_valid && in_ready)
                q.push_back('{ref_shift(int'(in_data), int'(in_shamt),
                                        int'(in_op)), cyc, stalls});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] s,
                        input logic [2:0] op);
        int n;
        bit acc;
        n   = 0;
        acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 1000);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    initial begin
        logic [7:0] b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        out_ready = 1'b1;
        idle(2);
        rst = 1'b0;

        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_zero", int'(out_zero), 0);

        chk("model_sll", ref_shift(8'hB5, 3, 0), 8'hA8);
        chk("model_srl", ref_shift(8'hB5, 3, 1), 8'h16);
        chk("model_sra", ref_shift(8'hB5, 3, 2), 8'hF6);
        chk("model_rol", ref_shift(8'hB5, 3, 3), 8'hAD);
        chk("model_ror", ref_shift(8'hB5, 3, 4), 8'hB6);
        chk("model_sra7", ref_shift(8'h80, 7, 2), 8'hFF);
        chk("model_sll7", ref_shift(8'h81, 7, 0), 8'h80);
        chk("model_pass", ref_shift(8'h3C, 5, 7), 8'h3C);

        for (int op = 0; op < 5; op++) send(8'hB5, 3'd3, 3'(op));
        idle(5);

        for (int i = 0; i < 8; i++) begin
            b = 8'h01 << i;
            send(b, 3'd1, 3'd0);
        end
        idle(5);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'(8'h11 * (i + 1)), 3'(i), 3'd3);
        idle(1);
        chk("bp_in_ready", int'(in_ready), 0);
        idle(5);
        chk("bp_hold_data", int'(out_data), ref_shift(8'h11, 0, 3));
        out_ready = 1'b1;
        send(8'h99, 3'd4, 3'd4);
        send(8'hC3, 3'd2, 3'd2);
        idle(6);

        for (int op = 0; op < 8; op++) send(8'h5A, 3'd0, 3'(op));
        send(8'h80, 3'd7, 3'd2);
        send(8'h81, 3'd7, 3'd0);
        send(8'h3C, 3'd5, 3'd7);
        idle(6);

        send(8'hF0, 3'd1, 3'd0);
        send(8'h0F, 3'd2, 3'd1);
        send(8'hAA, 3'd3, 3'd3);
        out_ready = 1'b0;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        out_ready = 1'b1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        send(8'h42, 3'd1, 3'd0);
        idle(6);

        rand_rdy = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            send(8'($urandom), 3'($urandom), 3'($urandom));
        end
        rand_rdy = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
